secuenciador_contador: RTL and testbench

SECUENCIADOR_CONTADOR -- requirements
Module: secuenciador_contador

---
 rtl/contador_pkg.sv | 22 ++
 rtl/contador_mod.sv | 30 +++
 rtl/secuenciador_contador.sv | 140 ++++++++++++++
 tb/tb_secuenciador_contador.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the BCD count sequencer and its digit counters.
package contador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] FREE_RUN = 8'h00;

  // A zero target or a digit the counters can never reach means count forever.
  function automatic logic is_free_run(input logic [7:0] target, input int modulo);
    return (target == FREE_RUN) ||
           (int'(target[3:0]) >= modulo) ||
           (int'(target[7:4]) >= modulo);
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Single modulo-N digit counter with synchronous clear and a combinational carry.
module contador_mod
  import contador_pkg::*;
#(
  parameter int MODULO = 10
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       CLR,
  input  logic       ENABLE,
  output logic [3:0] OUTPUT,
  output logic       CARRY
);

  bcd_t count;

  assign CARRY  = ENABLE && (count == 4'(MODULO - 1));
  assign OUTPUT = count;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= '0;
    end else if (CLR) begin
      count <= '0;
    end else if (ENABLE) begin
      count <= CARRY ? '0 : bcd_t'(count + 4'd1);
    end
  end

endmodule

// File: rtl/secuenciador_contador.sv
// Two-digit BCD count sequencer: prescaled ticks advance the digits until a latched
// target is reached, with start/pause/clear control.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | digits and prescaler held at zero, waiting for START
//   ST_RUN   | prescaler counting; each tick advances the digits
//   ST_PAUSE | digits and prescaler frozen, START resumes mid-period
//   ST_DONE  | target reached, digits frozen until CLEAR
module secuenciador_contador
  import contador_pkg::*;
#(
  parameter int PRESCALER = 50,
  parameter int MODULO    = 10
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic [7:0] TARGET,
  output logic [3:0] UNITS,
  output logic [3:0] TENS,
  output logic       RUNNING,
  output logic       DONE
);

  localparam int PW = (PRESCALER > 2) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER - 1);

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    target_q, target_n;
  logic          tick;
  logic          clr_digits;
  logic          units_carry, tens_carry;
  bcd_t          units_post, tens_post;

  contador_mod #(.MODULO(MODULO)) u_units (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .CLR    (clr_digits),
    .ENABLE (tick),
    .OUTPUT (UNITS),
    .CARRY  (units_carry)
  );

  contador_mod #(.MODULO(MODULO)) u_tens (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .CLR    (clr_digits),
    .ENABLE (units_carry),
    .OUTPUT (TENS),
    .CARRY  (tens_carry)
  );

  // Digit values that the counters will hold after this edge if a tick fires.
  always_comb begin
    units_post = units_carry ? '0 : bcd_t'(UNITS + 4'd1);
    if (tens_carry) begin
      tens_post = '0;
    end else if (units_carry) begin
      tens_post = bcd_t'(TENS + 4'd1);
    end else begin
      tens_post = TENS;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      presc    <= '0;
      target_q <= '0;
    end else begin
      state    <= state_n;
      presc    <= presc_n;
      target_q <= target_n;
    end
  end

  always_comb begin
    state_n    = state;
    presc_n    = presc;
    target_n   = target_q;
    tick       = 1'b0;
    clr_digits = CLEAR || (state == ST_IDLE);

    case (state)
      ST_IDLE: begin
        presc_n = '0;
        if (!CLEAR && !STOP && START) begin
          state_n  = ST_RUN;
          target_n = TARGET;
        end
      end

      ST_RUN: begin
        if (CLEAR) begin
          state_n = ST_IDLE;
          presc_n = '0;
        end else if (STOP) begin
          state_n = ST_PAUSE;
        end else if (presc == PRESC_LAST) begin
          tick    = 1'b1;
          presc_n = '0;
          if (!is_free_run(target_q, MODULO) && ({tens_post, units_post} == target_q)) begin
            state_n = ST_DONE;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (CLEAR) begin
          state_n = ST_IDLE;
          presc_n = '0;
        end else if (!STOP && START) begin
          state_n = ST_RUN;
        end
      end

      ST_DONE: begin
        if (CLEAR) begin
          state_n = ST_IDLE;
          presc_n = '0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        presc_n = '0;
      end
    endcase
  end

  assign RUNNING = (state == ST_RUN);
  assign DONE    = (state == ST_DONE);

endmodule

// File: tb/tb_secuenciador_contador.sv
// Directed-vector bench for secuenciador_contador with PRESCALER=4, MODULO=10.
module tb_secuenciador_contador;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       START, STOP, CLEAR;
  logic [7:0] TARGET;
  logic [3:0] UNITS, TENS;
  logic       RUNNING, DONE;

  int vectors    = 0;
  int miscompares = 0;

  secuenciador_contador #(.PRESCALER(4), .MODULO(10)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .START   (START),
    .STOP    (STOP),
    .CLEAR   (CLEAR),
    .TARGET  (TARGET),
    .UNITS   (UNITS),
    .TENS    (TENS),
    .RUNNING (RUNNING),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Compare {DONE, RUNNING, TENS, UNITS} against a hand-computed value.
  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {DONE, RUNNING, TENS, UNITS};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed done=%b run=%b digits=%h%h, expected done=%b run=%b digits=%h%h",
               tag, obs[9], obs[8], obs[7:4], obs[3:0], exp[9], exp[8], exp[7:4], exp[3:0]);
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    cyc(1);
    CLEAR = 1'b0;
  endtask

  initial begin
    RSTn = 1'b1; START = 1'b0; STOP = 1'b0; CLEAR = 1'b0; TARGET = 8'h00;

    // Asynchronous reset asserted between edges.
    #3 RSTn = 1'b0;
    #1 check("reset_async", {1'b0, 1'b0, 4'd0, 4'd0});
    cyc(2);
    RSTn = 1'b1;
    cyc(5);
    check("idle_after_reset", {1'b0, 1'b0, 4'd0, 4'd0});

    // Target 12: DONE exactly 48 edges after START is sampled.
    TARGET = 8'h12;
    pulse_start();
    cyc(24);
    check("run_tick6", {1'b0, 1'b1, 4'd0, 4'd6});
    cyc(23);
    check("run_edge47", {1'b0, 1'b1, 4'd1, 4'd1});
    cyc(1);
    check("target_done", {1'b1, 1'b0, 4'd1, 4'd2});
    TARGET = 8'h55;
    cyc(10);
    START = 1'b1; STOP = 1'b1;
    cyc(1);
    START = 1'b0; STOP = 1'b0;
    cyc(9);
    check("done_hold", {1'b1, 1'b0, 4'd1, 4'd2});
    pulse_clear();
    check("done_clear", {1'b0, 1'b0, 4'd0, 4'd0});

    // Pause after 10 edges: prescaler frozen at 1, resume needs 3 edges.
    TARGET = 8'h00;
    pulse_start();
    cyc(9);
    STOP = 1'b1;
    cyc(1);
    STOP = 1'b0;
    check("pause_enter", {1'b0, 1'b0, 4'd0, 4'd2});
    cyc(20);
    check("pause_hold", {1'b0, 1'b0, 4'd0, 4'd2});
    pulse_start();
    check("resume_run", {1'b0, 1'b1, 4'd0, 4'd2});
    cyc(2);
    check("resume_pre", {1'b0, 1'b1, 4'd0, 4'd2});
    cyc(1);
    check("resume_partial", {1'b0, 1'b1, 4'd0, 4'd3});

    // All three commands together: CLEAR wins.
    CLEAR = 1'b1; STOP = 1'b1; START = 1'b1;
    cyc(1);
    CLEAR = 1'b0; STOP = 1'b0; START = 1'b0;
    check("prio_clear", {1'b0, 1'b0, 4'd0, 4'd0});

    // STOP+START in RUN: PAUSE keeps prescaler at 2, so resume ticks after 2 edges.
    pulse_start();
    cyc(2);
    STOP = 1'b1; START = 1'b1;
    cyc(1);
    STOP = 1'b0; START = 1'b0;
    check("prio_stop", {1'b0, 1'b0, 4'd0, 4'd0});
    cyc(3);
    pulse_start();
    cyc(1);
    check("prio_resume_pre", {1'b0, 1'b1, 4'd0, 4'd0});
    cyc(1);
    check("prio_resume_tick", {1'b0, 1'b1, 4'd0, 4'd1});

    // Free-running wrap 99->00 at tick 100; TARGET change mid-run ignored.
    pulse_clear();
    TARGET = 8'h00;
    pulse_start();
    TARGET = 8'h05;
    cyc(396);
    check("wrap_99", {1'b0, 1'b1, 4'd9, 4'd9});
    cyc(4);
    check("wrap_00", {1'b0, 1'b1, 4'd0, 4'd0});
    cyc(20);
    check("wrap_after", {1'b0, 1'b1, 4'd0, 4'd5});

    // Reset during RUN at 37 discards progress.
    pulse_clear();
    TARGET = 8'h00;
    pulse_start();
    cyc(148);
    check("mid_37", {1'b0, 1'b1, 4'd3, 4'd7});
    #3 RSTn = 1'b0;
    #1 check("reset_mid", {1'b0, 1'b0, 4'd0, 4'd0});
    cyc(2);
    RSTn = 1'b1;
    cyc(2);
    check("idle_after_mid_reset", {1'b0, 1'b0, 4'd0, 4'd0});
    TARGET = 8'h01;
    pulse_start();
    cyc(3);
    check("t01_pre", {1'b0, 1'b1, 4'd0, 4'd0});
    cyc(1);
    check("t01_done", {1'b1, 1'b0, 4'd0, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
